// File: rtl/tri_cos_engine.sv
// Triangle classifier with law-of-cosines output via a shared restoring divider.
// Optional macro TRI_FAST_EQ_EN: equilateral inputs bypass the divider (cos = 0.5).
module tri_cos_engine #(
  parameter int LEN_W  = 8,
  parameter int FRAC_W = 13,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [LEN_W-1:0]        in_length,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_cos,
  output logic [1:0]              out_tri
);

  localparam int SQ_W  = 2 * LEN_W;
  localparam int N_W   = 2 * LEN_W + 2;
  localparam int D_W   = 2 * LEN_W + 1;
  localparam int Q_W   = FRAC_W + 2;
  localparam int BIT_W = $clog2(FRAC_W + 2);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAC_W + 1);
`ifdef TRI_FAST_EQ_EN
  localparam logic signed [OUT_W-1:0] COS_HALF = OUT_W'(2 ** (FRAC_W - 1));
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_CALC, S_OUT} state_t;

  state_t                    r_state;
  logic                      r_cnt;
  logic [LEN_W-1:0]          r_len  [3];
  logic [N_W-1:0]            r_nmag [3];
  logic                      r_nneg [3];
  logic [D_W-1:0]            r_den  [3];
  logic signed [OUT_W-1:0]   r_cos  [3];
  logic [N_W-1:0]            r_rem;
  logic [Q_W-2:0]            r_q;
  logic [BIT_W-1:0]          r_bit;
  logic [1:0]                r_idx;
  logic [1:0]                r_oidx;
  logic [1:0]                r_tri;

  logic [SQ_W-1:0]           w_sq  [3];
  logic [N_W-1:0]            w_num [3];
  logic [N_W-1:0]            w_mag [3];
  logic                      w_neg [3];
  logic [D_W-1:0]            w_den [3];
  logic                      w_invalid;
  logic [1:0]                w_type;
  logic [N_W-1:0]            w_trial;
  logic                      w_ge;
  logic [N_W-1:0]            w_rem_next;
  logic [Q_W-1:0]            w_q2;
  logic [Q_W-1:0]            w_rmag;
  logic signed [OUT_W-1:0]   w_cos;
`ifdef TRI_FAST_EQ_EN
  logic                      w_eq;
`endif

  assign busy = (r_state != S_IDLE);

  // Per-side numerators, denominators, validity and triangle type from the captured lengths.
  always_comb begin
    int j;
    int k;
    logic any_zero;
    logic any_neg;
    w_invalid = 1'b0;
    any_zero  = 1'b0;
    any_neg   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_sq[i] = SQ_W'(r_len[i]) * SQ_W'(r_len[i]);
    end
    for (int i = 0; i < 3; i++) begin
      j = (i + 1) % 3;
      k = (i + 2) % 3;
      w_num[i] = N_W'(w_sq[j]) + N_W'(w_sq[k]) - N_W'(w_sq[i]);
      w_neg[i] = w_num[i][N_W-1];
      w_mag[i] = w_neg[i] ? (N_W'(0) - w_num[i]) : w_num[i];
      w_den[i] = (D_W'(r_len[j]) * D_W'(r_len[k])) << 1;
      if ((r_len[i] == '0) ||
          ((LEN_W+1)'(r_len[i]) >= ((LEN_W+1)'(r_len[j]) + (LEN_W+1)'(r_len[k])))) begin
        w_invalid = 1'b1;
      end else begin
        w_invalid = w_invalid;
      end
      if (w_num[i] == '0) begin
        any_zero = 1'b1;
      end else begin
        any_zero = any_zero;
      end
      any_neg = any_neg | w_neg[i];
    end
    if (any_zero) begin
      w_type = 2'b01;
    end else if (any_neg) begin
      w_type = 2'b10;
    end else begin
      w_type = 2'b00;
    end
  end

`ifdef TRI_FAST_EQ_EN
  assign w_eq = (r_len[0] == r_len[1]) && (r_len[1] == r_len[2]) && (r_len[0] != '0);
`endif

  // One restoring-divider step; the first step of each cosine resolves the integer bit unshifted.
  always_comb begin
    w_trial    = (r_bit == '0) ? r_rem : {r_rem[N_W-2:0], 1'b0};
    w_ge       = (w_trial >= N_W'(r_den[0]));
    w_rem_next = w_ge ? (w_trial - N_W'(r_den[0])) : w_trial;
    w_q2       = {r_q, w_ge};
    w_rmag     = Q_W'(w_q2[Q_W-1:1]) + Q_W'(w_q2[0]);
    w_cos      = r_nneg[0] ? (OUT_W'(0) - OUT_W'(w_rmag)) : OUT_W'(w_rmag);
  end

  // Main controller: capture, classify, divide three times, then stream results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 1'b0;
      r_len     <= '{default: '0};
      r_nmag    <= '{default: '0};
      r_nneg    <= '{default: 1'b0};
      r_den     <= '{default: '0};
      r_cos     <= '{default: '0};
      r_rem     <= '0;
      r_q       <= '0;
      r_bit     <= '0;
      r_idx     <= 2'd0;
      r_oidx    <= 2'd0;
      r_tri     <= 2'd0;
      out_valid <= 1'b0;
      out_cos   <= '0;
      out_tri   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          out_valid <= 1'b0;
          out_cos   <= '0;
          out_tri   <= 2'd0;
          if (in_valid) begin
            r_len[0] <= in_length;
            r_cnt    <= 1'b0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!in_valid) begin
            r_state <= S_IDLE;
          end else if (!r_cnt) begin
            r_len[1] <= in_length;
            r_cnt    <= 1'b1;
          end else begin
            r_len[2] <= in_length;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_nmag <= w_mag;
          r_nneg <= w_neg;
          r_den  <= w_den;
          r_rem  <= w_mag[0];
          r_q    <= '0;
          r_bit  <= '0;
          r_idx  <= 2'd0;
          r_tri  <= w_type;
          r_oidx <= 2'd1;
          if (w_invalid) begin
            r_cos     <= '{default: '0};
            out_valid <= 1'b1;
            out_cos   <= '0;
            out_tri   <= 2'b11;
            r_state   <= S_OUT;
`ifdef TRI_FAST_EQ_EN
          end else if (w_eq) begin
            r_cos     <= '{default: COS_HALF};
            out_valid <= 1'b1;
            out_cos   <= COS_HALF;
            out_tri   <= 2'b00;
            r_state   <= S_OUT;
`endif
          end else begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_bit == LAST_BIT) begin
            // Results shift down so cos0 ends in slot 0 after the third division.
            r_cos[2]  <= w_cos;
            r_cos[1]  <= r_cos[2];
            r_cos[0]  <= r_cos[1];
            r_nmag[0] <= r_nmag[1];
            r_nmag[1] <= r_nmag[2];
            r_nneg[0] <= r_nneg[1];
            r_nneg[1] <= r_nneg[2];
            r_den[0]  <= r_den[1];
            r_den[1]  <= r_den[2];
            r_rem     <= r_nmag[1];
            r_q       <= '0;
            r_bit     <= '0;
            if (r_idx == 2'd2) begin
              out_valid <= 1'b1;
              out_cos   <= r_cos[1];
              out_tri   <= r_tri;
              r_oidx    <= 2'd1;
              r_state   <= S_OUT;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else begin
            r_rem <= w_rem_next;
            r_q   <= {r_q[Q_W-3:0], w_ge};
            r_bit <= r_bit + BIT_W'(1);
          end
        end
        S_OUT: begin
          case (r_oidx)
            2'd1: begin
              out_cos <= r_cos[1];
              out_tri <= 2'd0;
              r_oidx  <= 2'd2;
            end
            2'd2: begin
              out_cos <= r_cos[2];
              out_tri <= 2'd0;
              r_oidx  <= 2'd3;
            end
            default: begin
              out_valid <= 1'b0;
              out_cos   <= '0;
              out_tri   <= 2'd0;
              r_state   <= S_IDLE;
            end
          endcase
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_cos_engine.sv
// Randomized self-checking bench for tri_cos_engine with a real-arithmetic reference model.
module tb_tri_cos_engine;

  localparam int LEN_W  = 8;
  localparam int FRAC_W = 13;
  localparam int OUT_W  = 16;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic [LEN_W-1:0]        in_length;
  logic                    busy;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_cos;
  logic [1:0]              out_tri;

  int n_checks;
  int n_fail;

  tri_cos_engine #(.LEN_W(LEN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_length (in_length),
    .busy      (busy),
    .out_valid (out_valid),
    .out_cos   (out_cos),
    .out_tri   (out_tri)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Exact cosine of the angle opposite x, scaled and rounded half away from zero.
  function automatic int ref_cos(input int x, input int y, input int z);
    int  n;
    int  d;
    real q;
    int  m;
    n = y * y + z * z - x * x;
    d = 2 * y * z;
    q = (real'((n < 0) ? -n : n) * (2.0 ** FRAC_W)) / real'(d);
    m = int'($floor(q + 0.5));
    return (n < 0) ? -m : m;
  endfunction

  task automatic model(input int a0, input int a1, input int a2,
                       output int c0, output int c1, output int c2,
                       output int t, output int lat);
    int mx;
    int sm;
    int n0;
    int n1;
    int n2;
    mx = a0;
    if (a1 > mx) mx = a1;
    if (a2 > mx) mx = a2;
    sm = a0 + a1 + a2;
    if (a0 == 0 || a1 == 0 || a2 == 0 || mx >= sm - mx) begin
      c0 = 0; c1 = 0; c2 = 0; t = 3; lat = 2;
    end else begin
      c0 = ref_cos(a0, a1, a2);
      c1 = ref_cos(a1, a2, a0);
      c2 = ref_cos(a2, a0, a1);
      n0 = a1 * a1 + a2 * a2 - a0 * a0;
      n1 = a2 * a2 + a0 * a0 - a1 * a1;
      n2 = a0 * a0 + a1 * a1 - a2 * a2;
      if (n0 == 0 || n1 == 0 || n2 == 0) t = 1;
      else if (n0 < 0 || n1 < 0 || n2 < 0) t = 2;
      else t = 0;
      lat = 3 * (FRAC_W + 2) + 2;
`ifdef TRI_FAST_EQ_EN
      if (a0 == a1 && a1 == a2) lat = 2;
`endif
    end
  endtask

  // Drives one set starting in the current cycle and checks the whole response.
  task automatic run_tri(input int a0, input int a1, input int a2, input bit noise);
    int c0, c1, c2, t, el, lat;
    model(a0, a1, a2, c0, c1, c2, t, el);
    in_valid = 1'b1; in_length = LEN_W'(a0); step();
    in_length = LEN_W'(a1); step();
    in_length = LEN_W'(a2); step();
    in_valid = 1'b0;
    lat = 1;
    chk("busy_after_a2", int'(busy), 1);
    while (out_valid !== 1'b1 && lat < 200) begin
      if (noise && lat >= 5 && lat <= 8) begin
        in_valid  = 1'b1;
        in_length = LEN_W'($urandom_range(1, 255));
      end else begin
        in_valid = 1'b0;
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, el);
    if (out_valid === 1'b1) begin
      chk("cos0", int'(out_cos), c0);
      chk("tri", int'(out_tri), t);
      step();
      chk("ov1", int'(out_valid), 1);
      chk("cos1", int'(out_cos), c1);
      chk("tri1_zero", int'(out_tri), 0);
      step();
      chk("ov2", int'(out_valid), 1);
      chk("cos2", int'(out_cos), c2);
      chk("tri2_zero", int'(out_tri), 0);
      step();
      chk("ov_end", int'(out_valid), 0);
      chk("cos_gated", int'(out_cos), 0);
      chk("busy_end", int'(busy), 0);
    end
  endtask

  initial begin
    int seen;
    int a0, a1, a2;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_length = '0;
    repeat (3) step();
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_cos", int'(out_cos), 0);
    chk("rst_tri", int'(out_tri), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    step();

    run_tri(3, 4, 5, 1'b0);
    chk("plan_345_cos0", ref_cos(3, 4, 5), 6554);
    run_tri(2, 3, 4, 1'b1);
    run_tri(1, 2, 3, 1'b0);
    run_tri(0, 5, 5, 1'b0);
    run_tri(255, 255, 255, 1'b0);

    // Reset ten cycles into the divide phase.
    in_valid = 1'b1; in_length = 8'd3; step();
    in_length = 8'd4; step();
    in_length = 8'd5; step();
    in_valid = 1'b0;
    repeat (11) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ov", int'(out_valid), 0);
    chk("midrst_cos", int'(out_cos), 0);
    chk("midrst_busy", int'(busy), 0);
    seen = 0;
    repeat (60) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    chk("midrst_no_out", seen, 0);
    run_tri(5, 5, 6, 1'b0);

    // Truncated set must be discarded.
    in_valid = 1'b1; in_length = 8'd7; step();
    in_length = 8'd8; step();
    in_valid = 1'b0;
    seen = 0;
    repeat (100) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    chk("partial_no_out", seen, 0);
    chk("partial_busy", int'(busy), 0);
    run_tri(3, 4, 5, 1'b0);

    for (int n = 0; n < 30; n++) begin
      case (n % 3)
        0: begin
          a0 = $urandom_range(1, 255); a1 = $urandom_range(1, 255); a2 = $urandom_range(1, 255);
        end
        1: begin
          a0 = $urandom_range(0, 12); a1 = $urandom_range(0, 12); a2 = $urandom_range(0, 12);
        end
        default: begin
          a0 = $urandom_range(100, 255); a1 = $urandom_range(100, 255);
          a2 = $urandom_range(100, 255);
        end
      endcase
      run_tri(a0, a1, a2, n[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
